// File: rtl/sm_mem_arbiter.sv
// Purpose: shares one async-read / sync-write memory port between CPU I-fetch and D ports.
// Latency: request seen in IDLE -> WAIT_CYCLES+1 ACCESS cycles -> one-cycle ack (WAIT_CYCLES+2 after the request).
// Backpressure: requesters hold req until ack; a new grant is made only in IDLE, one transaction at a time.
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   i_req/i_addr -> i_ack/i_rdata       instruction read port
//   d_req/d_we/d_addr/d_wdata -> d_ack/d_rdata   data read/write port
//   m_addr/m_we/m_wdata, m_rdata        shared memory port (m_rdata combinational from m_addr)
//   busy                                high while a transaction is in ACCESS or ACK
module sm_mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [31:0] m_addr,
  output logic        m_we,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        busy
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t     state, stateNext;
  logic [3:0] waitCnt;
  logic       lastD;      // 1 = data port won the previous grant
  logic       grantD;     // port owning the current transaction
  logic       weQ;        // latched write flag of the current transaction
  logic       grantNow;
  logic       pickD;
  logic       lastAccess;

  // Next-state and arbitration decision
  always_comb begin
    stateNext = state;
    grantNow  = 1'b0;
    pickD     = 1'b0;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          grantNow  = 1'b1;
          // Lone requester wins; on a tie the port not granted last wins.
          pickD     = d_req && (!i_req || !lastD);
          stateNext = ACCESS;
        end
      end
      ACCESS: begin
        if (waitCnt == 4'd0) stateNext = ACK;
      end
      ACK:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      waitCnt <= 4'd0;
      lastD   <= 1'b0;
      grantD  <= 1'b0;
      weQ     <= 1'b0;
      m_addr  <= 32'd0;
      m_wdata <= 32'd0;
      i_rdata <= 32'd0;
      d_rdata <= 32'd0;
    end else begin
      state <= stateNext;
      if (grantNow) begin
        grantD  <= pickD;
        lastD   <= pickD;
        waitCnt <= WAIT_INIT;
        if (pickD) begin
          m_addr  <= d_addr;
          m_wdata <= d_wdata;
          weQ     <= d_we;
        end else begin
          m_addr  <= i_addr;
          weQ     <= 1'b0;
        end
      end else if (state == ACCESS) begin
        if (waitCnt != 4'd0) begin
          waitCnt <= waitCnt - 4'd1;
        end else if (!grantD) begin
          i_rdata <= m_rdata;
        end else if (!weQ) begin
          d_rdata <= m_rdata;
        end
      end
    end
  end

  // Outputs decode straight from registered state so reset clears them at once
  // and a write is only ever presented during the final ACCESS cycle.
  assign lastAccess = (state == ACCESS) && (waitCnt == 4'd0);
  assign m_we       = lastAccess && weQ;
  assign i_ack      = (state == ACK) && !grantD;
  assign d_ack      = (state == ACK) && grantD;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_sm_mem_arbiter.sv
// Bench for sm_mem_arbiter: three instances (WAIT_CYCLES 0, 1, 3) share stimulus,
// each with its own memory model.
module tb_sm_mem_arbiter;

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] CF = 32'hCAFEF00D;
  localparam logic [31:0] A5 = 32'hAAAA5555;
  localparam logic [31:0] W8 = 32'h55AA1234;
  localparam logic [31:0] WD = 32'h12345678;

  logic        clk;
  logic        rst_n;
  logic        iReq;
  logic [31:0] iAddr;
  logic        dReq;
  logic        dWe;
  logic [31:0] dAddr;
  logic [31:0] dWdata;

  logic        iAck   [3];
  logic [31:0] iRdata [3];
  logic        dAck   [3];
  logic [31:0] dRdata [3];
  logic [31:0] mAddr  [3];
  logic        mWe    [3];
  logic [31:0] mWdata [3];
  logic [31:0] mRdata [3];
  logic        busy   [3];

  logic        ldEn;
  logic [7:0]  ldAddr;
  logic [31:0] ldDat;

  int nCmp = 0;
  int nErr = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  genvar g;
  for (g = 0; g < 3; g++) begin : gInst
    localparam int WC = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    logic [31:0] mem [256];

    sm_mem_arbiter #(.WAIT_CYCLES(WC)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_req   (iReq),
      .i_addr  (iAddr),
      .i_ack   (iAck[g]),
      .i_rdata (iRdata[g]),
      .d_req   (dReq),
      .d_we    (dWe),
      .d_addr  (dAddr),
      .d_wdata (dWdata),
      .d_ack   (dAck[g]),
      .d_rdata (dRdata[g]),
      .m_addr  (mAddr[g]),
      .m_we    (mWe[g]),
      .m_wdata (mWdata[g]),
      .m_rdata (mRdata[g]),
      .busy    (busy[g])
    );

    assign mRdata[g] = mem[mAddr[g][7:0]];

    always @(posedge clk) begin
      if (mWe[g]) mem[mAddr[g][7:0]] <= mWdata[g];
      else if (ldEn) mem[ldAddr] <= ldDat;
    end
  end

  typedef struct {
    logic        iReq;
    logic [31:0] iAddr;
    logic        dReq;
    logic        dWe;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic        eIAck;
    logic        eDAck;
    logic        eBusy;
    logic        eMWe;
    logic [31:0] eMAddr;
    logic [31:0] eIRdata;
    logic [31:0] eDRdata;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic ir, logic [31:0] ia, logic dr, logic dw,
                              logic [31:0] da, logic [31:0] dwd,
                              logic eia, logic eda, logic eb, logic ew,
                              logic [31:0] ema, logic [31:0] eir, logic [31:0] edr);
    vec_t v;
    v.iReq = ir;  v.iAddr = ia;  v.dReq = dr;  v.dWe = dw;  v.dAddr = da;  v.dWdata = dwd;
    v.eIAck = eia; v.eDAck = eda; v.eBusy = eb; v.eMWe = ew;
    v.eMAddr = ema; v.eIRdata = eir; v.eDRdata = edr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    iReq = 1'b0; iAddr = 32'd0; dReq = 1'b0; dWe = 1'b0; dAddr = 32'd0; dWdata = 32'd0;
  endtask

  // Leaves the bench at the start of cycle 0 (just after a rising edge) with reset released.
  task automatic doReset();
    rst_n = 1'b0;
    idleInputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic ld(input logic [7:0] a, input logic [31:0] d);
    ldEn = 1'b1; ldAddr = a; ldDat = d;
    @(posedge clk); #1;
    ldEn = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    ldEn = 1'b0; ldAddr = 8'd0; ldDat = 32'd0;
    idleInputs();
    @(posedge clk); #1;
    ld(8'h10, DB);
    ld(8'h20, CF);
    ld(8'h40, A5);

    // Reset values on every instance
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk1($sformatf("rst%0d busy", k), busy[k], 1'b0);
      chk1($sformatf("rst%0d iAck", k), iAck[k], 1'b0);
      chk1($sformatf("rst%0d dAck", k), dAck[k], 1'b0);
      chk1($sformatf("rst%0d mWe", k), mWe[k], 1'b0);
      chk($sformatf("rst%0d mAddr", k), mAddr[k], 32'd0);
      chk($sformatf("rst%0d mWdata", k), mWdata[k], 32'd0);
      chk($sformatf("rst%0d iRdata", k), iRdata[k], 32'd0);
      chk($sformatf("rst%0d dRdata", k), dRdata[k], 32'd0);
    end

    // WAIT_CYCLES=0 stream: saturated tie from reset (D,I,D,I), single I read, D write then read-back.
    //           ir  iaddr   dr  we  daddr  wdata  iack dack busy mwe maddr   ird  drd
    vt.push_back(mk(1, 32'h40, 1, 0, 32'h20, 0,    0, 0, 0, 0, 32'h00, 0,  0 ));
    vt.push_back(mk(1, 32'h40, 1, 0, 32'h20, 0,    0, 0, 1, 0, 32'h20, 0,  0 ));
    vt.push_back(mk(1, 32'h40, 1, 0, 32'h20, 0,    0, 1, 1, 0, 32'h20, 0,  CF));
    vt.push_back(mk(1, 32'h40, 1, 0, 32'h10, 0,    0, 0, 0, 0, 32'h20, 0,  CF));
    vt.push_back(mk(1, 32'h40, 1, 0, 32'h10, 0,    0, 0, 1, 0, 32'h40, 0,  CF));
    vt.push_back(mk(1, 32'h40, 1, 0, 32'h10, 0,    1, 0, 1, 0, 32'h40, A5, CF));
    vt.push_back(mk(1, 32'h40, 1, 0, 32'h10, 0,    0, 0, 0, 0, 32'h40, A5, CF));
    vt.push_back(mk(1, 32'h40, 1, 0, 32'h10, 0,    0, 0, 1, 0, 32'h10, A5, CF));
    vt.push_back(mk(1, 32'h40, 1, 0, 32'h10, 0,    0, 1, 1, 0, 32'h10, A5, DB));
    vt.push_back(mk(1, 32'h40, 1, 0, 32'h10, 0,    0, 0, 0, 0, 32'h10, A5, DB));
    vt.push_back(mk(1, 32'h40, 1, 0, 32'h10, 0,    0, 0, 1, 0, 32'h40, A5, DB));
    vt.push_back(mk(0, 32'h40, 0, 0, 32'h10, 0,    1, 0, 1, 0, 32'h40, A5, DB));
    vt.push_back(mk(0, 32'h00, 0, 0, 32'h00, 0,    0, 0, 0, 0, 32'h40, A5, DB));
    vt.push_back(mk(1, 32'h10, 0, 0, 32'h00, 0,    0, 0, 0, 0, 32'h40, A5, DB));
    vt.push_back(mk(1, 32'h10, 0, 0, 32'h00, 0,    0, 0, 1, 0, 32'h10, A5, DB));
    vt.push_back(mk(0, 32'h10, 0, 0, 32'h00, 0,    1, 0, 1, 0, 32'h10, DB, DB));
    vt.push_back(mk(0, 32'h00, 0, 0, 32'h00, 0,    0, 0, 0, 0, 32'h10, DB, DB));
    vt.push_back(mk(0, 32'h00, 1, 1, 32'h80, W8,   0, 0, 0, 0, 32'h10, DB, DB));
    vt.push_back(mk(0, 32'h00, 1, 1, 32'h80, W8,   0, 0, 1, 1, 32'h80, DB, DB));
    vt.push_back(mk(0, 32'h00, 0, 1, 32'h80, W8,   0, 1, 1, 0, 32'h80, DB, DB));
    vt.push_back(mk(0, 32'h00, 1, 0, 32'h80, 0,    0, 0, 0, 0, 32'h80, DB, DB));
    vt.push_back(mk(0, 32'h00, 1, 0, 32'h80, 0,    0, 0, 1, 0, 32'h80, DB, DB));
    vt.push_back(mk(0, 32'h00, 0, 0, 32'h80, 0,    0, 1, 1, 0, 32'h80, DB, W8));
    vt.push_back(mk(0, 32'h00, 0, 0, 32'h00, 0,    0, 0, 0, 0, 32'h80, DB, W8));

    doReset();
    for (int k = 0; k < vt.size(); k++) begin
      iReq = vt[k].iReq; iAddr = vt[k].iAddr; dReq = vt[k].dReq;
      dWe = vt[k].dWe; dAddr = vt[k].dAddr; dWdata = vt[k].dWdata;
      @(negedge clk);
      chk1($sformatf("v%0d iAck", k), iAck[0], vt[k].eIAck);
      chk1($sformatf("v%0d dAck", k), dAck[0], vt[k].eDAck);
      chk1($sformatf("v%0d busy", k), busy[0], vt[k].eBusy);
      chk1($sformatf("v%0d mWe", k), mWe[0], vt[k].eMWe);
      chk($sformatf("v%0d mAddr", k), mAddr[0], vt[k].eMAddr);
      chk($sformatf("v%0d iRdata", k), iRdata[0], vt[k].eIRdata);
      chk($sformatf("v%0d dRdata", k), dRdata[0], vt[k].eDRdata);
      @(posedge clk); #1;
    end

    // WAIT_CYCLES=3 write to 0x40 aborted by reset in cycle 2, then a tie after release.
    doReset();
    dReq = 1'b1; dWe = 1'b1; dAddr = 32'h40; dWdata = WD;
    @(negedge clk);
    chk1("abort c0 busy", busy[2], 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("abort c1 busy", busy[2], 1'b1);
    chk("abort c1 mAddr", mAddr[2], 32'h40);
    chk("abort c1 mWdata", mWdata[2], WD);
    chk1("abort c1 mWe", mWe[2], 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk1("abort busy", busy[2], 1'b0);
    chk("abort mAddr", mAddr[2], 32'd0);
    chk("abort mWdata", mWdata[2], 32'd0);
    chk1("abort mWe", mWe[2], 1'b0);
    chk1("abort dAck", dAck[2], 1'b0);
    chk("abort dRdata", dRdata[2], 32'd0);
    dReq = 1'b0; dWe = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk1("abort hold dAck", dAck[2], 1'b0);
      chk1("abort hold mWe", mWe[2], 1'b0);
    end
    chk("abort mem40", gInst[2].mem[8'h40], A5);
    @(posedge clk); #1;
    rst_n = 1'b1;
    iReq = 1'b1; iAddr = 32'h10; dReq = 1'b1; dAddr = 32'h20; dWe = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 1) chk("tie mAddr", mAddr[2], 32'h20);
      chk1($sformatf("tie c%0d dAck", c), dAck[2], c == 5);
      chk1($sformatf("tie c%0d iAck", c), iAck[2], 1'b0);
      @(posedge clk); #1;
    end
    idleInputs();
    repeat (8) @(posedge clk);
    #1;

    // WAIT_CYCLES=3 write: busy window, single m_we cycle, memory update, ack.
    doReset();
    dReq = 1'b1; dWe = 1'b1; dAddr = 32'h40; dWdata = WD;
    for (int c = 0; c < 7; c++) begin
      if (c == 5) begin dReq = 1'b0; dWe = 1'b0; end
      @(negedge clk);
      chk1($sformatf("wr c%0d busy", c), busy[2], (c >= 1) && (c <= 5));
      chk1($sformatf("wr c%0d mWe", c), mWe[2], c == 4);
      chk1($sformatf("wr c%0d dAck", c), dAck[2], c == 5);
      if (c == 4) begin
        chk("wr mem40 before", gInst[2].mem[8'h40], A5);
        chk("wr mWdata", mWdata[2], WD);
      end
      if (c == 5) begin
        chk("wr mem40 after", gInst[2].mem[8'h40], WD);
        chk("wr dRdata", dRdata[2], 32'd0);
      end
      @(posedge clk); #1;
    end

    // WAIT_CYCLES=1 read whose request (and address) drops in cycle 1.
    doReset();
    iReq = 1'b1; iAddr = 32'h10;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin iReq = 1'b0; iAddr = 32'h40; end
      @(negedge clk);
      chk1($sformatf("drop c%0d iAck", c), iAck[1], c == 3);
      chk1($sformatf("drop c%0d busy", c), busy[1], (c >= 1) && (c <= 3));
      if (c == 2) chk("drop mAddr", mAddr[1], 32'h10);
      if (c == 3) chk("drop iRdata", iRdata[1], DB);
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
